// File: rtl/regfile_pkg.sv
// Shared constants and the write-port priority helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR  = 0;
  localparam int unsigned MAX_WR     = 2;
  localparam int unsigned WR_IDX_W   = 1;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] port;
  } wr_sel_t;

  // Highest-index asserted match wins, mirroring same-address write priority.
  function automatic wr_sel_t last_match(input logic [MAX_WR-1:0] match);
    wr_sel_t sel;
    sel = '0;
    for (int unsigned w = 0; w < MAX_WR; w++) begin
      if (match[w]) begin
        sel.hit  = 1'b1;
        sel.port = WR_IDX_W'(w);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write-back, issue and scoreboard signals of the multi-port register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [2**ADDR_W-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, issue wins a same-cycle collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  logic [2**ADDR_W-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_vec <= '0;
    else        busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; define REGFILE_BYPASS_EN to forward
// same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic [ADDR_W-1:0] ra;
`ifdef REGFILE_BYPASS_EN
  logic [MAX_WR-1:0] match;
  wr_sel_t           sel;
`endif

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .iss_en  (bus.iss_en),
    .iss_addr(bus.iss_addr),
    .busy_vec(busy_vec)
  );

  assign bus.busy_vec = busy_vec;

  // Ports are visited in ascending order so the highest-index port's data lands last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] &&
            !(ZERO_REG != 0 && bus.wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_ADDR)))
          regs[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
`ifdef REGFILE_BYPASS_EN
    match       = '0;
    sel         = '0;
`endif
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
      bus.rd_data[p*DATA_W +: DATA_W] = regs[ra];
      bus.rd_busy[p]                  = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed under reset since those writes never commit.
      match = '0;
      for (int unsigned w = 0; w < NUM_WR; w++)
        match[w] = reset && bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] == ra);
      sel = last_match(match);
      if (sel.hit) begin
        bus.rd_data[p*DATA_W +: DATA_W] = bus.wr_data[int'(sel.port)*DATA_W +: DATA_W];
        bus.rd_busy[p]                  = bus.iss_en && (bus.iss_addr == ra);
      end
`endif
      if (ZERO_REG != 0 && ra == ADDR_W'(ZERO_ADDR)) begin
        bus.rd_data[p*DATA_W +: DATA_W] = '0;
        bus.rd_busy[p]                  = 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with an integrated busy scoreboard, replacing the fixed 32x32 two-read/one-write register file in the datapath. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with register 0 optionally hardwired to zero. A per-register busy bit is set when an instruction issues to a destination and cleared on write-back, so decode can detect RAW hazards. It sits between decode/issue (read and issue ports) and write-back (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes and issues
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all registers and busy bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of the addressed register
- wr_en  in  NUM_WR  write enable per port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  ADDR_W  destination register being issued
- busy_vec  out  2**ADDR_W  full scoreboard, bit r = register r busy

## Operation
- Storage: 2**ADDR_W x DATA_W flops; busy: 2**ADDR_W flops.
- Write: on rising edge, for each w with wr_en[w], reg[wr_addr[w]] <= wr_data[w]; busy[wr_addr[w]] cleared.
- Same-address write conflict: highest-index enabled port wins data.
- Issue: iss_en sets busy[iss_addr] on rising edge.
- Issue and write-back to same register in the same cycle: busy ends set (new producer wins); data still written.
- ZERO_REG=1: writes and issues to address 0 ignored; rd_data for address 0 is 0 and rd_busy is 0, regardless of bypass.
- Read: rd_data/rd_busy combinational from rd_addr and current state (plus bypass, see Configuration).
- Reads on different ports are independent; any ports may share an address.
- Reset asserted mid-operation: all registers and busy bits clear immediately (asynchronous), write/issue inputs ignored while reset low.

## Timing
- Write latency: data visible on rd_data in the cycle after the write edge (0 cycles with bypass).
- Issue latency: busy visible one cycle after the issue edge; never bypassed.
- Read latency: 0 cycles (combinational).
- Reset values: rd_data = 0, rd_busy = 0, busy_vec = 0 while reset low and until first write/issue.
- First edge after reset deasserts performs normal writes/issues.

## Configuration
- REGFILE_BYPASS_EN defined: each read port whose address matches an enabled write port in the current cycle returns that port's wr_data (highest-index match wins) and rd_busy = 0 for that port unless iss_en targets the same address in that cycle, in which case rd_busy = 1.
- Not defined: reads return stored state only; same-cycle write is seen next cycle.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants, ZERO_ADDR constant, helper function for highest-index write-port match.
- Sub-module regfile_scoreboard: busy-bit array with iss/clear logic and busy_vec output; data array and read muxes stay in regfile_mp.

## Test plan
- Reset low with wr_en=2'b11 -> all rd_data 0, busy_vec 0; release, write reg 2 = 32'h98635533 -> next cycle rd_addr 2 reads 32'h98635533.
- Write reg 0 = 32'hAFAFAFAF with ZERO_REG=1 -> rd_data 0; iss_addr 0 -> busy_vec[0] stays 0.
- Both write ports to reg 5, data 32'h1111_1111 (port 0) and 32'h2222_2222 (port 1) -> reg 5 = 32'h2222_2222.
- iss_en to reg 7 -> busy_vec[7]=1 next cycle; write-back reg 7 = 32'h0000_00FF -> busy clears, data visible next cycle; iss and write to reg 7 same cycle -> busy stays 1.
- With REGFILE_BYPASS_EN: write reg 3 = 32'hDEADBEEF while rd_addr 3 -> same-cycle rd_data 32'hDEADBEEF, rd_busy 0; without the macro -> old value, stored busy.
- Assert reset asynchronously between edges after loading regs 1..4 -> rd_data 0 before next edge.
